onehot_sequence_encoder: RTL and testbench
==========================================

# onehot_sequence_encoder

Receive-side counterpart of the counter-driven 3-to-8 decoder. Samples an 8-line one-hot bus, re-encodes it to a 3-bit code, checks one-hot legality, and verifies that successive codes advance by +1 modulo 8. Used as a self-check on the decoder outputs: it locks onto the count sequence and flags illegal patterns and sequence breaks.

## Interface
Parameters:
- LOCK_CNT, default 2: number of consecutive +1 matches required to enter LOCKED (legal range 1..7).
- ERR_CNT_W, default 8: width of the error counter.

Ports:
- clkin  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  capture onehot_in on this edge.
- onehot_in  in  8  decoder lines; bit i high means code i.
- code_out  out  3  last legally encoded code.
- code_valid  out  1  one-cycle pulse: legal sample encoded.
- onehot_err  out  1  one-cycle pulse: sample had zero or more than one bit set.
- seq_err  out  1  one-cycle pulse: sequence break detected while LOCKED.
- locked  out  1  level; high in LOCKED state.
- err_count  out  ERR_CNT_W  saturating count of onehot_err plus seq_err events.

## Operation
- Encode: popcount(onehot_in)==1 gives legal, code = index of the set bit; otherwise illegal.
- Legal sample: code_out <= code, code_valid pulses.
- Illegal sample: onehot_err pulses, code_out holds, code_valid stays low.
- expected register (3 bits) = previous legal code + 1. Wraps 7 to 0, pure 3-bit arithmetic.
- match_cnt register counts consecutive matches, range 0..LOCK_CNT.
- FSM states are UNLOCKED, LOCKING, and LOCKED. Transitions, all evaluated only on sample_en:
  - UNLOCKED, legal sample: go to LOCKING; expected <= code+1; match_cnt <= 0.
  - UNLOCKED, illegal sample: stay in UNLOCKED.
  - LOCKING, legal and code==expected: match_cnt++; on reaching LOCK_CNT go to LOCKED.
  - LOCKING, legal and mismatch: stay in LOCKING; re-reference on the new code (expected <= code+1, match_cnt <= 0).
  - LOCKING, illegal sample: go to UNLOCKED.
  - LOCKED, legal and match: stay in LOCKED.
  - LOCKED, legal and mismatch: seq_err pulses; go to LOCKING, re-referenced on the new code.
  - LOCKED, illegal sample: onehot_err pulses; go to UNLOCKED. seq_err does not pulse.
- A repeated identical code counts as a mismatch.
- err_count increments by 1 per sample that raises either pulse. Only one pulse per sample is possible. Saturates at all-ones.

## Timing
- Latency: all outputs are registered. Effects of a sample on edge N are visible after edge N, for one cycle in the case of pulses.
- sample_en low: no state change, all pulses low, levels hold.
- Back-to-back sample_en every cycle is supported at full rate.
- Reset values: code_out=0, code_valid=0, onehot_err=0, seq_err=0, locked=0, err_count=0, state UNLOCKED, expected=0, match_cnt=0.
- rst high together with sample_en: reset wins and the sample is discarded.
- Reset mid-lock: the next legal sample restarts from UNLOCKED.
- locked rises on the same edge as the code_valid pulse of the LOCK_CNT-th match. It falls on the edge of the breaking sample.

## Configuration
- ONEHOT_ENC_ERR_CNT_EN defined: err_count is a real ERR_CNT_W-bit saturating counter.
- ONEHOT_ENC_ERR_CNT_EN undefined: no counter flops; err_count is tied to 0. All other behaviour is identical.

## Structure
- Package onehot_enc_pkg holds:
  - constants N_LINES=8 and CODE_W=3;
  - a state enum type with UNLOCKED, LOCKING, and LOCKED.
- One sub-module, onehot_check: purely combinational. Takes onehot_in and produces legal and code. Instantiated once.
- FSM, expected/match_cnt registers, and error counter live in onehot_sequence_encoder.

## Test plan
- Reset, then samples 0,1,2,3 with LOCK_CNT=2 -> code_valid pulses each time; locked rises on the sample of code 2 and stays high through 3; err_count=0.
- Locked, samples 6,7,0,1 -> wrap accepted; locked stays high; seq_err never pulses.
- Locked at code 3, sample 5 -> seq_err pulse, locked falls, code_out=5, err_count=1. Then samples 6,7 -> locked rises again.
- Locked, sample onehot_in=8'h00, then 8'h11 -> two onehot_err pulses; code_out holds; locked falls on the first; err_count=2 (0 with macro undefined).
- ERR_CNT_W=2, five illegal samples -> err_count saturates at 3.
- Locked, then rst and sample_en high on the same edge with legal code -> all outputs 0, no code_valid; the next sample 4 enters LOCKING only.

Source files
------------

// File: rtl/onehot_enc_pkg.sv
// Shared constants and FSM state type for the one-hot sequence encoder.
package onehot_enc_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_sequence_encoder_onehot_check.sv
// Combinational one-hot legality check and re-encoding of the decoder lines.
module onehot_check
    import onehot_enc_pkg::*;
(
    input  logic [N_LINES-1:0] onehot_in,
    output logic               legal,
    output logic [CODE_W-1:0]  code
);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    always_comb begin
        legal = (onehot_in != '0) && ((onehot_in & (onehot_in - 1'b1)) == '0);
        code  = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (onehot_in[i]) begin
                code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_sequence_encoder.sv
// Re-encodes a one-hot decoder bus, locks onto the +1 count sequence and flags breaks.
// Optional saturating error counter enabled by defining ONEHOT_ENC_ERR_CNT_EN.
module onehot_sequence_encoder
    import onehot_enc_pkg::*;
#(
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clkin,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [N_LINES-1:0]   onehot_in,
    output logic [CODE_W-1:0]    code_out,
    output logic                 code_valid,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           state_dbg
);

    localparam int MATCH_W = 3;
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

    state_t              state;
    logic [CODE_W-1:0]   expected;
    logic [MATCH_W-1:0]  match_cnt;
    logic                legal;
    logic [CODE_W-1:0]   code;
    logic                is_match;
    logic                err_event;

    onehot_check u_check (
        .onehot_in (onehot_in),
        .legal     (legal),
        .code      (code)
    );

    assign is_match  = (code == expected);
    assign state_dbg = state;
    assign err_event = sample_en && (!legal || (state == LOCKED && !is_match));

    always_ff @(posedge clkin) begin
        if (rst) begin
            state      <= UNLOCKED;
            expected   <= '0;
            match_cnt  <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            if (sample_en) begin
                if (!legal) begin
                    onehot_err <= 1'b1;
                    state      <= UNLOCKED;
                    match_cnt  <= '0;
                    locked     <= 1'b0;
                end else begin
                    code_out   <= code;
                    code_valid <= 1'b1;
                    expected   <= code + 1'b1;
                    case (state)
                        UNLOCKED: begin
                            state     <= LOCKING;
                            match_cnt <= '0;
                        end
                        LOCKING: begin
                            if (is_match) begin
                                match_cnt <= match_cnt + 1'b1;
                                if (match_cnt + 1'b1 == LOCK_TGT) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            // A break re-references on the new code rather than dropping to UNLOCKED.
                            if (!is_match) begin
                                seq_err   <= 1'b1;
                                state     <= LOCKING;
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end
                        default: begin
                            state     <= UNLOCKED;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef ONEHOT_ENC_ERR_CNT_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_event && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
    assign err_count        = '0;
`endif

endmodule

// File: tb/tb_onehot_sequence_encoder.sv
// Directed bench: a sequence-level reference model checked every cycle plus literal pins.
module tb_onehot_sequence_encoder;

    localparam int LOCK_CNT = 2;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] onehot_in = 8'h00;

    logic [2:0] code_out, code_out2;
    logic       code_valid, onehot_err, seq_err, locked;
    logic       code_valid2, onehot_err2, seq_err2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [1:0] state_dbg, state_dbg2;

    int total = 0;
    int bad = 0;

    // Reference model: sequence-level view (last code, run of +1 steps, error tally).
    logic [2:0] m_code = '0;
    logic       m_valid = 0, m_oherr = 0, m_seqerr = 0, m_locked = 0;
    int         m_errs = 0;
    bit         have_ref = 0;
    int         run = 0;

    always #5 clkin = ~clkin;

    onehot_sequence_encoder #(.LOCK_CNT(LOCK_CNT), .ERR_CNT_W(8)) dut (
        .clkin(clkin), .rst(rst), .sample_en(sample_en), .onehot_in(onehot_in),
        .code_out(code_out), .code_valid(code_valid), .onehot_err(onehot_err),
        .seq_err(seq_err), .locked(locked), .err_count(err_count), .state_dbg(state_dbg)
    );

    onehot_sequence_encoder #(.LOCK_CNT(LOCK_CNT), .ERR_CNT_W(2)) dut2 (
        .clkin(clkin), .rst(rst), .sample_en(sample_en), .onehot_in(onehot_in),
        .code_out(code_out2), .code_valid(code_valid2), .onehot_err(onehot_err2),
        .seq_err(seq_err2), .locked(locked2), .err_count(err_count2), .state_dbg(state_dbg2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clkin) begin
        int ones;
        int idx;
        m_valid  = 0;
        m_oherr  = 0;
        m_seqerr = 0;
        if (rst) begin
            m_code = '0; m_locked = 0; m_errs = 0; have_ref = 0; run = 0;
        end else if (sample_en) begin
            ones = 0;
            idx  = 0;
            for (int i = 0; i < 8; i++) begin
                if (onehot_in[i]) begin
                    ones++;
                    idx = i;
                end
            end
            if (ones != 1) begin
                m_oherr = 1;
                m_errs++;
                have_ref = 0;
                run = 0;
            end else begin
                m_valid = 1;
                if (have_ref && idx == ((int'(m_code) + 1) % 8)) begin
                    run++;
                end else begin
                    if (m_locked) begin
                        m_seqerr = 1;
                        m_errs++;
                    end
                    run = 0;
                end
                have_ref = 1;
                m_code = 3'(idx);
            end
            m_locked = have_ref && (run >= LOCK_CNT);
        end
    end

    always @(negedge clkin) begin
        check("code_out", code_out, m_code);
        check("code_valid", code_valid, m_valid);
        check("onehot_err", onehot_err, m_oherr);
        check("seq_err", seq_err, m_seqerr);
        check("locked", locked, m_locked);
`ifdef ONEHOT_ENC_ERR_CNT_EN
        check("err_count", err_count, sat(m_errs, 255));
        check("err_count_w2", err_count2, sat(m_errs, 3));
`else
        check("err_count", err_count, 0);
        check("err_count_w2", err_count2, 0);
`endif
    end

    // Apply one cycle of inputs; returns just after the sampling edge.
    task automatic step(input logic r, input logic en, input logic [7:0] v);
        rst = r;
        sample_en = en;
        onehot_in = v;
        @(posedge clkin);
        #1;
        rst = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic samp(input int c);
        logic [7:0] v;
        v = 8'h01 << c;
        step(1'b0, 1'b1, v);
    endtask

    initial begin
        int errs_lit;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("rst_code", code_out, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err_count, 0);

        samp(0); check("lit_locked_0", locked, 0); check("lit_valid_0", code_valid, 1);
        samp(1); check("lit_locked_1", locked, 0);
        samp(2); check("lit_locked_2", locked, 1); check("lit_model_locked", m_locked, 1);
        samp(3); check("lit_code_3", code_out, 3);
        step(1'b0, 1'b0, 8'h40);
        check("lit_idle_code", code_out, 3); check("lit_idle_valid", code_valid, 0);

        for (int c = 4; c < 8; c++) samp(c);
        samp(0); samp(1);
        check("lit_wrap_locked", locked, 1); check("lit_wrap_seq", seq_err, 0);
        samp(2); samp(3);

        samp(5);
        check("lit_break_seq", seq_err, 1); check("lit_break_locked", locked, 0);
        check("lit_break_code", code_out, 5);
`ifdef ONEHOT_ENC_ERR_CNT_EN
        errs_lit = 1;
`else
        errs_lit = 0;
`endif
        check("lit_break_err", err_count, errs_lit);
        samp(6); check("lit_relock_6", locked, 0);
        samp(7); check("lit_relock_7", locked, 1);

        step(1'b0, 1'b1, 8'h00);
        check("lit_zero_oherr", onehot_err, 1); check("lit_zero_locked", locked, 0);
        check("lit_zero_seq", seq_err, 0);
        step(1'b0, 1'b1, 8'h11);
        check("lit_multi_oherr", onehot_err, 1); check("lit_multi_code", code_out, 7);
`ifdef ONEHOT_ENC_ERR_CNT_EN
        errs_lit = 3;
`endif
        check("lit_multi_err", err_count, errs_lit);

        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h81);
        step(1'b0, 1'b1, 8'hC0);
`ifdef ONEHOT_ENC_ERR_CNT_EN
        check("lit_sat_w2", err_count2, 3);
        check("lit_cnt_w8", err_count, 8);
`else
        check("lit_sat_w2", err_count2, 0);
`endif

        samp(0); samp(1); samp(2);
        check("lit_lock_again", locked, 1);
        samp(2);
        check("lit_repeat_seq", seq_err, 1); check("lit_repeat_locked", locked, 0);
        samp(3); samp(4);
        check("lit_lock_after_repeat", locked, 1);

        step(1'b1, 1'b1, 8'h20);
        check("lit_rst_valid", code_valid, 0); check("lit_rst_code", code_out, 0);
        check("lit_rst_locked", locked, 0); check("lit_rst_errc", err_count, 0);
        samp(4);
        check("lit_after_rst_code", code_out, 4); check("lit_after_rst_locked", locked, 0);
        samp(5); check("lit_after_rst_5", locked, 0);
        samp(6); check("lit_after_rst_6", locked, 1);
        step(1'b0, 1'b0, 8'h00);

        @(negedge clkin);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
